alu_seq: RTL and testbench

- Parametrised, registered successor to the vending-machine 4-bit ALU. Operations: add, subtract, multiply, compare (A >= B).
- Uses a start/done handshake. Add, subtract and compare complete in one cycle; multiply is a WIDTH-cycle shift-add.
- Sits between the coin/price datapath and the controller FSM, which issues one operation at a time and waits for done.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_seq.sv | 47 ++++
 rtl/alu_seq.sv | 97 +++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, state encoding and sizing helper for the sequential ALU
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-step shift-add multiplier core; prod is the accumulator after the current step
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 last
);

    localparam int CW = clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign prod = acc + (mplier[0] ? mcand : '0);
    assign last = (cnt == CW'(WIDTH - 1));

    // load operands on accept, then one add/shift per step; counter saturates at WIDTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
        end else if (step) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= (cnt == CW'(WIDTH)) ? cnt : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered add/sub/mul/cmp ALU with start/done handshake; ALU_SAT_SUB_EN selects saturating subtract
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_en,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 s0,
    input  logic                 s1,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 borrow
);

    state_t             state, state_nxt;
    logic [1:0]         op;
    logic               accept;
    logic               mul_last;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   diff;
    logic               lt;
    logic [2*WIDTH-1:0] op_res;

    assign op     = {s1, s0};
    assign accept = alu_en && start && (state == ST_IDLE);
    assign busy   = (state == ST_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && op == OP_MUL),
        .step  (alu_en && state == ST_MUL),
        .a     (a),
        .b     (b),
        .prod  (prod),
        .last  (mul_last)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next state: disable aborts, mul runs WIDTH steps, single-cycle ops stay idle
    always_comb begin
        state_nxt = state;
        if (!alu_en)                          state_nxt = ST_IDLE;
        else if (accept && op == OP_MUL)      state_nxt = ST_MUL;
        else if (state == ST_MUL && mul_last) state_nxt = ST_IDLE;
    end

    // single-cycle results straight from the live operands at the accepting edge
    always_comb begin
        lt  = a < b;
        sum = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
`ifdef ALU_SAT_SUB_EN
        diff = lt ? '0 : a - b;
`else
        diff = a - b;
`endif
        op_res = (op == OP_ADD) ? sum :
                 (op == OP_SUB) ? {{WIDTH{1'b0}}, diff} :
                 (op == OP_CMP) ? {{(2*WIDTH-1){1'b0}}, ~lt} : '0;
    end

    // result/done/borrow registers; done is a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            done   <= 1'b0;
            borrow <= 1'b0;
        end else if (!alu_en) begin
            result <= '0;
            done   <= 1'b0;
            borrow <= 1'b0;
        end else if (state == ST_MUL && mul_last) begin
            result <= prod;
            done   <= 1'b1;
            borrow <= 1'b0;
        end else if (accept && op != OP_MUL) begin
            result <= op_res;
            done   <= 1'b1;
            borrow <= (op == OP_SUB) && lt;
        end else begin
            done   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven check of alu_seq at WIDTH=4 plus abort, back-to-back and reset sequences
module tb_alu_seq;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic alu_en = 1'b1;
    logic start = 1'b0;
    logic s0 = 1'b0;
    logic s1 = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic busy, done, borrow;
    logic [2*W-1:0] result;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_en (alu_en),
        .start  (start),
        .a      (a),
        .b      (b),
        .s0     (s0),
        .s1     (s1),
        .busy   (busy),
        .done   (done),
        .result (result),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        logic           brw;
        int             lat;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive a request at a negedge; operands are scrambled after acceptance
    task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        {s1, s0} = op;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~x;
        b = ~y;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc = 0;
        while (!done && lat < 20) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc, dcnt;
        vt[0]  = '{2'b00, 4'd9,  4'd5,  8'h0E, 1'b0, 1};
        vt[1]  = '{2'b00, 4'd15, 4'd15, 8'h1E, 1'b0, 1};
        vt[2]  = '{2'b01, 4'd6,  4'd3,  8'h03, 1'b0, 1};
`ifdef ALU_SAT_SUB_EN
        vt[3]  = '{2'b01, 4'd3,  4'd6,  8'h00, 1'b1, 1};
`else
        vt[3]  = '{2'b01, 4'd3,  4'd6,  8'h0D, 1'b1, 1};
`endif
        vt[4]  = '{2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 5};
        vt[5]  = '{2'b10, 4'd3,  4'd0,  8'h00, 1'b0, 5};
        vt[6]  = '{2'b11, 4'd5,  4'd6,  8'h00, 1'b0, 1};
        vt[7]  = '{2'b11, 4'd6,  4'd6,  8'h01, 1'b0, 1};
        vt[8]  = '{2'b10, 4'd7,  4'd3,  8'h15, 1'b0, 5};
`ifdef ALU_SAT_SUB_EN
        vt[9]  = '{2'b01, 4'd0,  4'd1,  8'h00, 1'b1, 1};
`else
        vt[9]  = '{2'b01, 4'd0,  4'd1,  8'h0F, 1'b1, 1};
`endif
        vt[10] = '{2'b11, 4'd9,  4'd2,  8'h01, 1'b0, 1};

        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_borrow", borrow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            wait_done(lat, bc);
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_result", i), result, vt[i].res);
            chk($sformatf("v%0d_borrow", i), borrow, vt[i].brw);
            chk($sformatf("v%0d_busy_cycles", i), bc, (vt[i].op == 2'b10) ? W : 0);
            @(negedge clk);
            chk($sformatf("v%0d_done_width", i), done, 0);
            chk($sformatf("v%0d_result_hold", i), result, vt[i].res);
        end

        // mul aborted by alu_en drop, with an ignored add request while busy
        dcnt = 0;
        {s1, s0} = 2'b10; a = 4'd7; b = 4'd3; start = 1'b1;
        @(negedge clk);
        chk("abort_busy_on", busy, 1);
        {s1, s0} = 2'b00; a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        dcnt += done;
        start = 1'b0;
        alu_en = 1'b0;
        @(negedge clk);
        chk("abort_result", result, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        alu_en = 1'b1;
        repeat (8) begin
            @(negedge clk);
            dcnt += done;
        end
        chk("abort_no_done", dcnt, 0);
        issue(2'b00, 4'd2, 4'd2);
        wait_done(lat, bc);
        chk("reen_latency", lat, 1);
        chk("reen_result", result, 8'h04);
        @(negedge clk);

        // back-to-back: new start accepted in the cycle done is high
        {s1, s0} = 2'b00; a = 4'd1; b = 4'd2; start = 1'b1;
        @(negedge clk);
        chk("b2b_done1", done, 1);
        chk("b2b_res1", result, 8'h03);
        a = 4'd4; b = 4'd4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done2", done, 1);
        chk("b2b_res2", result, 8'h08);
        @(negedge clk);
        chk("b2b_done_low", done, 0);

        // asynchronous reset mid-multiply
        issue(2'b10, 4'd15, 4'd15);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            dcnt += done;
        end
        chk("arst_no_done", dcnt, 0);
        chk("arst_result_after", result, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
